// File: rtl/mac_rx_frame_check.sv
// mac_rx_frame_check: registers the receive word stream, polices sof/eof framing and length, counts frames
module mac_rx_frame_check #(
  parameter int DATA_WIDTH = 32,
  parameter int MIN_WORDS  = 16,
  parameter int MAX_WORDS  = 384,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] phy_rx_data,
  input  logic                  phy_rx_valid,
  input  logic                  phy_rx_sof,
  input  logic                  phy_rx_eof,
  input  logic                  phy_rx_err,
  output logic [DATA_WIDTH-1:0] mac_rx_data,
  output logic                  mac_rx_valid,
  output logic                  mac_rx_sof,
  output logic                  mac_rx_eof,
  output logic                  mac_rx_fr_good,
  output logic                  mac_rx_fr_err,
  output logic [CNT_WIDTH-1:0]  stat_good_cnt,
  output logic [CNT_WIDTH-1:0]  stat_err_cnt,
  output logic [CNT_WIDTH-1:0]  stat_orphan_cnt
);
  localparam int WCW = $clog2(MAX_WORDS + 2);
  typedef enum logic [1:0] {IDLE, FRAME, DROP} state_t;
  state_t state, nxt;
  logic [WCW-1:0] wcnt, len;
  logic errflag, start, in_fr, judge, fwd, o_eof, good, bad, orph;
  // a sof in DROP is handled exactly like a sof in IDLE
  assign start = phy_rx_valid && phy_rx_sof && state != FRAME;
  assign in_fr = phy_rx_valid && state == FRAME;
  assign len   = start ? WCW'(1) : wcnt + 1'b1;
  // state register with running word count and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      errflag <= 1'b0;
    end else begin
      state <= nxt;
      if (start) begin
        wcnt    <= WCW'(1);
        errflag <= phy_rx_err;
      end else if (in_fr) begin
        wcnt    <= wcnt + 1'b1;
        errflag <= errflag | phy_rx_err;
      end
    end
  end
  // next state: a restarting sof or eof closes the frame, overflow truncates into DROP
  always_comb begin
    nxt = state;
    if (start) nxt = phy_rx_eof ? IDLE : FRAME;
    else if (in_fr) nxt = (phy_rx_sof || phy_rx_eof) ? IDLE : (wcnt == WCW'(MAX_WORDS)) ? DROP : FRAME;
    else if (phy_rx_valid && state == DROP && phy_rx_eof) nxt = IDLE;
  end
  // per-word outputs; restart and overflow close the frame as errored without judging length
  always_comb begin
    fwd   = start || in_fr;
    o_eof = (start && phy_rx_eof) || (in_fr && (phy_rx_sof || phy_rx_eof || wcnt == WCW'(MAX_WORDS)));
    judge = (start && phy_rx_eof) || (in_fr && !phy_rx_sof && phy_rx_eof);
    good  = judge && !(phy_rx_err || (in_fr && errflag)) && len >= WCW'(MIN_WORDS) && len <= WCW'(MAX_WORDS);
    bad   = o_eof && !good;
    orph  = phy_rx_valid && !phy_rx_sof && state == IDLE;
  end
  // output register stage; data holds across idle and discarded words
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_rx_data    <= '0;
      mac_rx_valid   <= 1'b0;
      mac_rx_sof     <= 1'b0;
      mac_rx_eof     <= 1'b0;
      mac_rx_fr_good <= 1'b0;
      mac_rx_fr_err  <= 1'b0;
    end else begin
      if (fwd) mac_rx_data <= phy_rx_data;
      mac_rx_valid   <= fwd;
      mac_rx_sof     <= start;
      mac_rx_eof     <= o_eof;
      mac_rx_fr_good <= good;
      mac_rx_fr_err  <= bad;
    end
  end
  // saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_good_cnt   <= '0;
      stat_err_cnt    <= '0;
      stat_orphan_cnt <= '0;
    end else begin
      if (good && !(&stat_good_cnt)) stat_good_cnt <= stat_good_cnt + 1'b1;
      if (bad && !(&stat_err_cnt)) stat_err_cnt <= stat_err_cnt + 1'b1;
      if (orph && !(&stat_orphan_cnt)) stat_orphan_cnt <= stat_orphan_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mac_rx_frame_check.sv
// tb_mac_rx_frame_check: directed frames with hand-computed outputs and counters
module tb_mac_rx_frame_check;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] phy_rx_data = '0;
  logic phy_rx_valid = 1'b0, phy_rx_sof = 1'b0, phy_rx_eof = 1'b0, phy_rx_err = 1'b0;
  logic [31:0] mac_rx_data;
  logic mac_rx_valid, mac_rx_sof, mac_rx_eof, mac_rx_fr_good, mac_rx_fr_err;
  logic [15:0] stat_good_cnt, stat_err_cnt, stat_orphan_cnt;
  int checks = 0;
  int errors = 0;
  int eg = 0, ee = 0, eo = 0;
  mac_rx_frame_check dut (
    .clk(clk), .rst(rst),
    .phy_rx_data(phy_rx_data), .phy_rx_valid(phy_rx_valid), .phy_rx_sof(phy_rx_sof),
    .phy_rx_eof(phy_rx_eof), .phy_rx_err(phy_rx_err),
    .mac_rx_data(mac_rx_data), .mac_rx_valid(mac_rx_valid), .mac_rx_sof(mac_rx_sof),
    .mac_rx_eof(mac_rx_eof), .mac_rx_fr_good(mac_rx_fr_good), .mac_rx_fr_err(mac_rx_fr_err),
    .stat_good_cnt(stat_good_cnt), .stat_err_cnt(stat_err_cnt), .stat_orphan_cnt(stat_orphan_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // flags are {valid,sof,eof,good,err}; data compared only when valid is expected
  task automatic out(input string tag, input logic [4:0] f, input logic [31:0] d);
    chk({tag, " flags"}, {27'b0, mac_rx_valid, mac_rx_sof, mac_rx_eof, mac_rx_fr_good, mac_rx_fr_err}, {27'b0, f});
    if (f[4]) chk({tag, " data"}, mac_rx_data, d);
  endtask
  task automatic cnts(input string tag);
    chk({tag, " good_cnt"}, {16'b0, stat_good_cnt}, eg);
    chk({tag, " err_cnt"}, {16'b0, stat_err_cnt}, ee);
    chk({tag, " orphan_cnt"}, {16'b0, stat_orphan_cnt}, eo);
  endtask
  task automatic drive(input logic v, input logic s, input logic e, input logic r, input logic [31:0] d);
    phy_rx_valid = v; phy_rx_sof = s; phy_rx_eof = e; phy_rx_err = r; phy_rx_data = d;
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (2) drive(0, 0, 0, 0, 32'hdead);
    out("reset", 5'b00000, 0);
    chk("reset data", mac_rx_data, 0);
    cnts("reset");
    rst = 1'b0;
    // 1: clean 20-word frame
    for (int i = 0; i < 20; i++) begin
      drive(1, i == 0, i == 19, 0, i);
      out("t1", {1'b1, i == 0, i == 19, i == 19, 1'b0}, i);
    end
    eg = 1; cnts("t1");
    // 2: same frame with a gap before every third word
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 2) begin
        drive(0, 0, 0, 0, 32'hbad);
        out("t2 gap", 5'b00000, 0);
        chk("t2 hold", mac_rx_data, 100 + i - 1);
      end
      drive(1, i == 0, i == 19, 0, 100 + i);
      out("t2", {1'b1, i == 0, i == 19, i == 19, 1'b0}, 100 + i);
    end
    eg = 2; cnts("t2");
    // 3: runt frame of 4 words
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, i == 3, 0, 200 + i);
      out("t3", {1'b1, i == 0, i == 3, 1'b0, i == 3}, 200 + i);
    end
    ee = 1; cnts("t3");
    // 4: PHY error on word 5 of a 20-word frame
    for (int i = 0; i < 20; i++) begin
      drive(1, i == 0, i == 19, i == 5, 300 + i);
      out("t4", {1'b1, i == 0, i == 19, 1'b0, i == 19}, 300 + i);
    end
    ee = 2; cnts("t4");
    // 5: 400-word frame truncated at word 384, rest discarded silently
    for (int i = 0; i < 400; i++) begin
      drive(1, i == 0, i == 399, 0, 1000 + i);
      out("t5", {i <= 384, i == 0, i == 384, 1'b0, i == 384}, 1000 + i);
    end
    chk("t5 hold", mac_rx_data, 1384);
    ee = 3; cnts("t5");
    for (int i = 0; i < 20; i++) begin
      drive(1, i == 0, i == 19, 0, 2000 + i);
      out("t5b", {1'b1, i == 0, i == 19, i == 19, 1'b0}, 2000 + i);
    end
    eg = 3; cnts("t5b");
    // single-word frame is below minimum length
    drive(1, 1, 1, 0, 32'h55);
    out("single", 5'b11101, 32'h55);
    ee = 4; cnts("single");
    // 6: sof re-asserted on word 10, eof on word 15
    for (int i = 0; i < 16; i++) begin
      drive(1, i == 0 || i == 10, i == 15, 0, 3000 + i);
      if (i < 10) out("t6", {1'b1, i == 0, 3'b000}, 3000 + i);
      else if (i == 10) out("t6 restart", 5'b10101, 3010);
      else out("t6 orphan", 5'b00000, 0);
    end
    ee = 5; eo = 5; cnts("t6");
    // reset in the middle of a frame
    for (int i = 0; i < 3; i++) drive(1, i == 0, 0, 0, 4000 + i);
    out("pre-rst", 5'b10000, 4002);
    rst = 1'b1;
    drive(1, 0, 0, 0, 4003);
    out("mid rst", 5'b00000, 0);
    chk("mid rst data", mac_rx_data, 0);
    eg = 0; ee = 0; eo = 0; cnts("mid rst");
    rst = 1'b0;
    drive(1, 0, 1, 0, 4004);
    out("post rst", 5'b00000, 0);
    eo = 1; cnts("post rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
